// File: rtl/bsg_manycore_pkg.sv
// Shared manycore types and helpers.
// Loader arbiter state encoding and width helpers.
package bsg_manycore_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    FENCE = 2'd2,
    DONE  = 2'd3
  } bsg_manycore_loader_arb_state_e;

  // Bits needed to hold values 0..n inclusive.
  function automatic int bsg_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int bsg_safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin winner select; pointer moves past each served requester.
// Grant locking is the caller's job.
module bsg_arb_round_robin
  import bsg_manycore_pkg::*;
#(
  parameter int width_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] reqs_i,
  output logic [width_p-1:0] grants_o,
  input  logic [width_p-1:0] yumi_i
);

  localparam int ptr_w_lp = bsg_safe_clog2(width_p);

  logic [ptr_w_lp-1:0] ptr_r;
  logic [ptr_w_lp-1:0] idx;
  logic                found;

  // First requester at or after the pointer wins.
  always_comb begin
    grants_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < width_p; i++) begin
      idx = ptr_w_lp'((int'(ptr_r) + i) % width_p);
      if (!found && reqs_i[idx]) begin
        grants_o[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  // Highest priority goes to the one after the last served.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_r <= '0;
    end else begin
      for (int j = 0; j < width_p; j++) begin
        if (yumi_i[j]) begin
          ptr_r <= (j == width_p - 1) ? '0 : ptr_w_lp'(j + 1);
        end
      end
    end
  end

endmodule

// File: rtl/bsg_nonsynth_manycore_loader_arbiter.sv
// Shares one manycore injection port among several loader streams.
// Round-robin with grant lock, credit gating and fence draining.
module bsg_nonsynth_manycore_loader_arbiter
  import bsg_manycore_pkg::*;
#(
  parameter int num_req_p               = 2,
  // must be set by the instantiator to the network packet width
  parameter int packet_width_p          = 32,
  parameter int max_out_credits_p       = 200,
  parameter int credit_counter_width_lp = bsg_width(max_out_credits_p),
  parameter int credit_limit_p          = max_out_credits_p
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [num_req_p-1:0]               v_i,
  input  logic [num_req_p*packet_width_p-1:0] packet_i,
  output logic [num_req_p-1:0]               yumi_o,
  input  logic [num_req_p-1:0]               fence_i,
  output logic [num_req_p-1:0]               fence_done_o,
  input  logic [num_req_p-1:0]               done_i,
  output logic [packet_width_p-1:0]          packet_o,
  output logic                               v_o,
  input  logic                               ready_i,
  input  logic [credit_counter_width_lp-1:0] out_credits_used_i,
  output logic                               done_o
);

  localparam int idx_w_lp = bsg_safe_clog2(num_req_p);
  localparam logic [credit_counter_width_lp-1:0] limit_lp =
    credit_counter_width_lp'(credit_limit_p);

  bsg_manycore_loader_arb_state_e state_r;

  logic [idx_w_lp-1:0]       grant_r;
  logic [idx_w_lp-1:0]       win_idx;
  logic [idx_w_lp-1:0]       sel;
  logic [num_req_p-1:0]      req;
  logic [num_req_p-1:0]      win;
  logic [packet_width_p-1:0] pkts [num_req_p];
  logic                      credit_ok;
  logic                      credit_zero;
  logic                      all_done;
  logic                      fence_win;
  logic                      send_ok;

  for (genvar k = 0; k < num_req_p; k++) begin : g_slice
    assign pkts[k] = packet_i[k*packet_width_p +: packet_width_p];
  end

  // A stream with both set asks for its fence first.
  assign req         = v_i | fence_i;
  assign all_done    = &done_i;
  assign credit_ok   = out_credits_used_i < limit_lp;
  assign credit_zero = out_credits_used_i == '0;
  assign fence_win   = |(win & fence_i);
  assign send_ok     = |(win & v_i & ~fence_i) && credit_ok;

  bsg_arb_round_robin #(
    .width_p (num_req_p)
  ) rr (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .reqs_i   (req),
    .grants_o (win),
    .yumi_i   (yumi_o | fence_done_o)
  );

  // Convert the one-hot winner to an index.
  always_comb begin
    win_idx = '0;
    for (int k = 0; k < num_req_p; k++) begin
      if (win[k]) win_idx = idx_w_lp'(k);
    end
  end

  assign sel      = (state_r == SEND) ? grant_r : win_idx;
  assign packet_o = pkts[sel];
  assign done_o   = (state_r == DONE);

  // Handshake outputs; reset silences them without waiting for a clock.
  always_comb begin
    v_o          = 1'b0;
    yumi_o       = '0;
    fence_done_o = '0;
    if (!reset_i) begin
      unique case (state_r)
        IDLE: begin
          if (send_ok) begin
            v_o    = 1'b1;
            yumi_o = ready_i ? win : '0;
          end
        end
        SEND: begin
          v_o = 1'b1;
          if (ready_i) yumi_o[grant_r] = 1'b1;
        end
        FENCE: begin
          if (credit_zero) fence_done_o[grant_r] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Arbiter state and locked grant.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      grant_r <= '0;
    end else begin
      unique case (state_r)
        IDLE: begin
          if (all_done && req == '0) begin
            state_r <= DONE;
          end else if (fence_win) begin
            grant_r <= win_idx;
            state_r <= FENCE;
          end else if (send_ok && !ready_i) begin
            grant_r <= win_idx;
            state_r <= SEND;
          end
        end
        SEND:  if (ready_i) state_r <= IDLE;
        FENCE: if (credit_zero) state_r <= IDLE;
        DONE:  state_r <= DONE;
        default: state_r <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  logic [packet_width_p-1:0] lock_r;
  logic                      info_r;

  // Remember the offered packet and flag stream protocol violations.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lock_r <= '0;
    end else begin
      if (state_r != SEND) lock_r <= pkts[sel];
      if (state_r == SEND && (!v_i[grant_r] || pkts[grant_r] !== lock_r))
        $error("loader_arb: locked stream %0d changed its packet", grant_r);
      if (state_r == FENCE && !fence_i[grant_r])
        $error("loader_arb: stream %0d dropped fence early", grant_r);
      if (state_r == DONE && |req)
        $error("loader_arb: request after done");
      if (!$onehot0(yumi_o) || !$onehot0(fence_done_o) ||
          (|yumi_o && |fence_done_o))
        $error("loader_arb: service pulses not one-hot");
    end
  end

  // Announce completion once.
  always_ff @(negedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      info_r <= 1'b0;
    end else if (done_o && !info_r) begin
      info_r <= 1'b1;
      $display("[BSG_INFO][LOADER_ARB] all streams done, t=%0t", $time);
    end
  end
`endif

endmodule
